// File: rtl/rr_arb_nx1.sv
// Round-robin N-to-1 arbiter with a registered valid/ready output stage.
// A rotating pointer gives first claim to the requester after the last winner.
module rr_arb_nx1 #(
    parameter int M = 2,
    parameter int N = 2**M,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [M-1:0]   sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   dout
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [M-1:0]   ptr;
    logic [M-1:0]   winner;
    logic [M-1:0]   idx;
    logic           found;
    logic           window;
    logic           grant;
    logic [W-1:0]   wdata;

    // Scan ptr, ptr+1, ... with natural M-bit wrap; first active request wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < N; k++) begin
            idx = ptr + M'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == M'(i)) begin
                wdata = din[i*W +: W];
            end
        end
    end

    assign window = (state == EMPTY) || out_ready;
    assign grant  = window && found && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: an open window either refills or drains the stage
    always_comb begin
        state_nxt = state;
        if (window) begin
            state_nxt = found ? FULL : EMPTY;
        end
    end

    // Output logic
    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[winner] = 1'b1;
        end
        out_valid = (state == FULL);
    end

    // Captured word, its source index and the rotating priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            sel  <= '0;
            ptr  <= '0;
        end else if (grant) begin
            dout <= wdata;
            sel  <= winner;
            ptr  <= winner + M'(1);
        end
    end

endmodule
